mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-low. Ports: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset.
REQ-002 iMissReq input 1, iCache line-fill request; iMissAddr input 32, fill word address.
REQ-003 dMissReq input 1, dCache line-fill request; dMissAddr input 32, fill word address.
REQ-004 dEvictReq input 1, dCache dirty-line write request; dEvictAddr input 32, write word address; dEvictData input 512, line to write.
REQ-005 hostReq output 1, host transaction valid; hostWrite output 1, 1=write, 0=read; hostAddr output 32, line address; hostWrData output 512, write line.
REQ-006 hostReady input 1, host accepts the transaction; hostRdValid input 1, read data valid; hostRdData input 512, read line; hostWrDone input 1, write committed.
REQ-007 mcInstrValid output 1, iCache fill pulse; mcInstrIn output 512, iCache fill line; mcDataValid output 1, dCache fill pulse; mcDataIn output 512, dCache fill line; evictDone output 1, evict-complete pulse.
REQ-008 busy output 1, high in any state other than IDLE; timeoutErr output 1, sticky watchdog error.

Function
REQ-009 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-010 IDLE: grant priority SHALL be dEvictReq, then dMissReq/iMissReq round-robin. The RR pointer SHALL favour D after reset and SHALL flip to the other side after each fill grant.
REQ-011 On grant, the block SHALL register the requester ID, address (bits [3:0] forced to 0, 16-word line) and write data, then enter ISSUE; hostReq SHALL rise the cycle after the request is sampled.
REQ-012 ISSUE: hostReq, hostWrite, hostAddr and hostWrData SHALL hold stable until hostReady is sampled high, then the FSM SHALL enter WAIT and deassert hostReq.
REQ-013 WAIT (read) SHALL exit on hostRdValid: the block SHALL capture hostRdData into the target line register and enter RESP. WAIT (write) SHALL exit on hostWrDone and enter RESP. hostWrDone SHALL be ignored during a read, and hostRdValid during a write.
REQ-014 RESP SHALL assert exactly one 1-cycle pulse (mcInstrValid, mcDataValid or evictDone) with the line stable on the matching bus, then return to IDLE. Fill latency is hostRdValid at cycle u -> valid pulse at u+1.
REQ-015 Requesters SHALL hold req and address until their pulse. In the first IDLE cycle after RESP, the just-served requester SHALL be masked from arbitration.
REQ-016 mcInstrIn and mcDataIn SHALL retain their last value between pulses.
REQ-017 hostRdValid and hostWrDone in IDLE or ISSUE SHALL be ignored.
REQ-018 Only one host transaction SHALL be outstanding at a time. Requests arriving while busy SHALL wait, with no loss.

Reset
REQ-019 rst low SHALL force IDLE, clear the RR pointer to D, and zero every output and every internal register, including mid-transaction. An in-flight host transaction is abandoned and no completion pulse is issued for it.

Configuration
REQ-020 With MEM_ARB_TIMEOUT_EN defined, a 10-bit counter SHALL count cycles in ISSUE/WAIT. On reaching 1023, the block SHALL set timeoutErr (sticky until reset), drop hostReq, return to IDLE without a pulse, and clear the counter on every state entry.
REQ-021 Without MEM_ARB_TIMEOUT_EN, the timeoutErr port SHALL remain present and tied to 0, with no counter logic.

Verification
REQ-022 iMissReq=1, iMissAddr=0x0000_1237; hostReady at the 2nd ISSUE cycle; hostRdValid with data 0xA5..A5 3 cycles later -> hostAddr=0x0000_1230, hostWrite=0, mcInstrValid one cycle after hostRdValid with mcInstrIn=0xA5..A5.
REQ-023 dEvictReq, dMissReq and iMissReq asserted in the same cycle -> grant order evict (hostWrite=1), dMiss, iMiss; evictDone, mcDataValid and mcInstrValid pulse once each, in that order.
REQ-024 dMissReq and iMissReq held continuously for 4 fills -> grants alternate D, I, D, I.
REQ-025 rst low while in WAIT, then hostRdValid after release -> all outputs 0, no valid pulse, and the FSM is IDLE.
REQ-026 MEM_ARB_TIMEOUT_EN defined, hostReady never asserted -> after 1023 cycles timeoutErr=1, hostReq=0, busy=0; timeoutErr stays 1 until rst. Without the macro, timeoutErr stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - line-fill / evict arbiter in front of a single-outstanding host port
// Optional watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         iMissReq,
  input  logic [31:0]  iMissAddr,
  input  logic         dMissReq,
  input  logic [31:0]  dMissAddr,
  input  logic         dEvictReq,
  input  logic [31:0]  dEvictAddr,
  input  logic [511:0] dEvictData,
  output logic         hostReq,
  output logic         hostWrite,
  output logic [31:0]  hostAddr,
  output logic [511:0] hostWrData,
  input  logic         hostReady,
  input  logic         hostRdValid,
  input  logic [511:0] hostRdData,
  input  logic         hostWrDone,
  output logic         mcInstrValid,
  output logic [511:0] mcInstrIn,
  output logic         mcDataValid,
  output logic [511:0] mcDataIn,
  output logic         evictDone,
  output logic         busy,
  output logic         timeoutErr
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  localparam logic [1:0] ID_I = 2'd0, ID_D = 2'd1, ID_E = 2'd2;

  state_t       r_state, w_next;
  logic [1:0]   r_id, r_mask_id, w_gid;
  logic [31:0]  r_addr, w_gaddr;
  logic [511:0] r_wdata, r_line_i, r_line_d;
  logic         r_rr_i, r_mask_vld;
  logic         w_ev_req, w_d_req, w_i_req, w_grant, w_tmo;

  // The requester served last is hidden for one IDLE cycle so its stale req is not re-granted.
  always_comb begin
    w_ev_req = dEvictReq & ~(r_mask_vld & (r_mask_id == ID_E));
    w_d_req  = dMissReq  & ~(r_mask_vld & (r_mask_id == ID_D));
    w_i_req  = iMissReq  & ~(r_mask_vld & (r_mask_id == ID_I));
    w_grant  = 1'b0;
    w_gid    = ID_I;
    w_gaddr  = iMissAddr;
    if (w_ev_req) begin
      w_grant = 1'b1;
      w_gid   = ID_E;
      w_gaddr = dEvictAddr;
    end else if (w_d_req && (!w_i_req || !r_rr_i)) begin
      w_grant = 1'b1;
      w_gid   = ID_D;
      w_gaddr = dMissAddr;
    end else if (w_i_req) begin
      w_grant = 1'b1;
      w_gid   = ID_I;
      w_gaddr = iMissAddr;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next = S_ISSUE;
      S_ISSUE: if (hostReady) w_next = S_WAIT;
      S_WAIT:  if ((r_id == ID_E) ? hostWrDone : hostRdValid) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_tmo) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_id       <= ID_I;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_line_i   <= '0;
      r_line_d   <= '0;
      r_rr_i     <= 1'b0;
      r_mask_vld <= 1'b0;
      r_mask_id  <= ID_I;
    end else begin
      r_state    <= w_next;
      r_mask_vld <= (r_state == S_RESP);
      r_mask_id  <= r_id;
      if (r_state == S_IDLE && w_grant) begin
        r_id    <= w_gid;
        r_addr  <= w_gaddr & ~32'hF;
        r_wdata <= (w_gid == ID_E) ? dEvictData : '0;
        if (w_gid != ID_E) r_rr_i <= (w_gid == ID_D);
      end
      if (r_state == S_WAIT && hostRdValid && !w_tmo) begin
        if (r_id == ID_I) r_line_i <= hostRdData;
        if (r_id == ID_D) r_line_d <= hostRdData;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [9:0] r_tmo_cnt;
  logic       r_tmo_err;
  logic       w_active;

  assign w_active   = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_tmo      = w_active && (r_tmo_cnt == 10'd1023);
  assign timeoutErr = r_tmo_err;

  // Counter restarts whenever the FSM changes state, so it measures time spent in one state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (w_next != r_state) r_tmo_cnt <= '0;
      else if (w_active)     r_tmo_cnt <= r_tmo_cnt + 10'd1;
      if (w_tmo) r_tmo_err <= 1'b1;
    end
  end
`else
  assign w_tmo      = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  assign hostReq      = (r_state == S_ISSUE);
  assign hostWrite    = (r_id == ID_E);
  assign hostAddr     = r_addr;
  assign hostWrData   = r_wdata;
  assign mcInstrValid = (r_state == S_RESP) && (r_id == ID_I);
  assign mcDataValid  = (r_state == S_RESP) && (r_id == ID_D);
  assign evictDone    = (r_state == S_RESP) && (r_id == ID_E);
  assign mcInstrIn    = r_line_i;
  assign mcDataIn     = r_line_d;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic         clk = 1'b0, rst;
  logic         iMissReq, dMissReq, dEvictReq;
  logic [31:0]  iMissAddr, dMissAddr, dEvictAddr;
  logic [511:0] dEvictData, hostRdData;
  logic         hostReady, hostRdValid, hostWrDone;
  logic         hostReq, hostWrite, mcInstrValid, mcDataValid, evictDone, busy, timeoutErr;
  logic [31:0]  hostAddr;
  logic [511:0] hostWrData, mcInstrIn, mcDataIn;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .iMissReq(iMissReq), .iMissAddr(iMissAddr),
    .dMissReq(dMissReq), .dMissAddr(dMissAddr),
    .dEvictReq(dEvictReq), .dEvictAddr(dEvictAddr), .dEvictData(dEvictData),
    .hostReq(hostReq), .hostWrite(hostWrite), .hostAddr(hostAddr), .hostWrData(hostWrData),
    .hostReady(hostReady), .hostRdValid(hostRdValid), .hostRdData(hostRdData), .hostWrDone(hostWrDone),
    .mcInstrValid(mcInstrValid), .mcInstrIn(mcInstrIn),
    .mcDataValid(mcDataValid), .mcDataIn(mcDataIn),
    .evictDone(evictDone), .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // kind: 0 = iCache fill, 1 = dCache fill, 2 = evict write
  typedef struct {logic [1:0] kind; logic [31:0] addr; logic [511:0] data;} txn_t;
  txn_t         exp_q[$];
  txn_t         cur;
  event         txn_ev;
  int           due = -1;
  logic [1:0]   due_kind;
  logic [511:0] due_line, m_line_i, m_line_d;
  bit           host_auto = 1, noise = 0, slow_drop = 0;
  int           rdy_dly = 1, rsp_dly = 3;
  int           left_i, left_d, left_e, cnt_i, cnt_d, cnt_e;

  function automatic txn_t mk(input logic [1:0] k, input logic [31:0] a, input logic [511:0] d);
    txn_t t;
    t.kind = k; t.addr = a; t.data = d;
    return t;
  endfunction

  function automatic logic [511:0] rd_line(input logic [31:0] a);
    if (a == 32'h1230) return {64{8'hA5}};
    return {16{a ^ 32'h5A5A_0000}};
  endfunction

  // Model: expected grants come from exp_q, expected pulses from the host responder's completions.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (hostReq && !prev_req) begin
          if (exp_q.size() == 0) check("unexpected_grant", {511'd0, hostReq}, 512'd0);
          else begin
            cur = exp_q.pop_front();
            -> txn_ev;
          end
        end
        if (hostReq) begin
          check("host_addr", hostAddr, cur.addr);
          check("host_write", hostWrite, cur.kind == 2'd2);
          if (cur.kind == 2'd2) check("host_wrdata", hostWrData, cur.data);
          check("busy_in_issue", busy, 1);
        end
        if (cyc == due) begin
          check("pulse_vec", {mcInstrValid, mcDataValid, evictDone},
                (due_kind == 2'd0) ? 3'b100 : (due_kind == 2'd1) ? 3'b010 : 3'b001);
          if (due_kind == 2'd0) m_line_i = due_line;
          if (due_kind == 2'd1) m_line_d = due_line;
          due = -1;
        end else begin
          check("no_pulse", {mcInstrValid, mcDataValid, evictDone}, 3'b000);
        end
        check("instr_line", mcInstrIn, m_line_i);
        check("data_line", mcDataIn, m_line_d);
        if (mcInstrValid) cnt_i++;
        if (mcDataValid) cnt_d++;
        if (evictDone) cnt_e++;
      end
      prev_req = hostReq;
    end
  end

  // Host responder; with noise it also drives strobes that must be ignored.
  initial forever begin
    @(txn_ev);
    if (host_auto) begin
      repeat (rdy_dly) begin @(posedge clk); #1; end
      hostReady = 1'b1;
      if (noise) begin hostRdValid = 1'b1; hostWrDone = 1'b1; hostRdData = {16{32'hBAD0_BAD0}}; end
      @(posedge clk); #1;
      hostReady = 1'b0; hostRdValid = 1'b0; hostWrDone = 1'b0;
      check("req_drop", hostReq, 0);
      if (noise) begin
        if (cur.kind == 2'd2) hostRdValid = 1'b1;
        else hostWrDone = 1'b1;
      end
      repeat (rsp_dly - 1) begin @(posedge clk); #1; hostRdValid = 1'b0; hostWrDone = 1'b0; end
      if (cur.kind == 2'd2) hostWrDone = 1'b1;
      else begin hostRdValid = 1'b1; hostRdData = rd_line(cur.addr); end
      due      = cyc + 1;
      due_kind = cur.kind;
      due_line = (cur.kind == 2'd2) ? '0 : rd_line(cur.addr);
      @(posedge clk); #1;
      hostRdValid = 1'b0; hostWrDone = 1'b0; hostRdData = {16{32'hDEAD_BEEF}};
    end
  end

  // Requesters drop their req once the configured number of pulses has been seen.
  initial forever begin
    @(negedge clk);
    if (rst && mcInstrValid && left_i > 0) begin
      left_i--;
      if (left_i == 0) begin if (slow_drop) @(negedge clk); iMissReq = 1'b0; end
    end
    if (rst && mcDataValid && left_d > 0) begin
      left_d--;
      if (left_d == 0) begin if (slow_drop) @(negedge clk); dMissReq = 1'b0; end
    end
    if (rst && evictDone && left_e > 0) begin
      left_e--;
      if (left_e == 0) begin if (slow_drop) @(negedge clk); dEvictReq = 1'b0; end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    {iMissReq, dMissReq, dEvictReq, hostReady, hostRdValid, hostWrDone} = '0;
    {iMissAddr, dMissAddr, dEvictAddr} = '0;
    dEvictData = '0; hostRdData = '0;
    exp_q.delete(); due = -1; m_line_i = '0; m_line_d = '0;
    {left_i, left_d, left_e, cnt_i, cnt_d, cnt_e} = '0;
    noise = 0; slow_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hostReq", hostReq, 0);
    check("rst_hostWrite", hostWrite, 0);
    check("rst_hostAddr", hostAddr, 0);
    check("rst_hostWrData", hostWrData, 0);
    check("rst_pulses", {mcInstrValid, mcDataValid, evictDone}, 0);
    check("rst_mcInstrIn", mcInstrIn, 0);
    check("rst_mcDataIn", mcDataIn, 0);
    check("rst_busy", busy, 0);
    check("rst_timeoutErr", timeoutErr, 0);
    rst = 1'b1;
  endtask

  task automatic wait_req(input int lim);
    int k = 0;
    while (!hostReq && k < lim) begin @(negedge clk); k++; end
    check("req_seen", hostReq, 1);
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    do begin @(negedge clk); k++; end
    while (!(!iMissReq && !dMissReq && !dEvictReq && !busy) && k < lim);
    check("idle_reached", k < lim, 1);
  endtask

  initial begin
    do_reset();

    // Single iCache fill with the canonical timing.
    iMissAddr = 32'h0000_1237; iMissReq = 1'b1; left_i = 1;
    exp_q.push_back(mk(2'd0, 32'h0000_1230, '0));
    wait_idle(100);
    check("A_hostAddr", hostAddr, 32'h0000_1230);
    check("A_hostWrite", hostWrite, 0);
    check("A_line", mcInstrIn, {64{8'hA5}});
    check("A_cnt_i", cnt_i, 1);

    // Evict, dMiss and iMiss together; requesters are slow to drop.
    do_reset();
    noise = 1; slow_drop = 1;
    dEvictAddr = 32'h0000_8008; dEvictData = {16{32'hC0FF_EE00}}; dEvictReq = 1'b1; left_e = 1;
    dMissAddr = 32'h0000_2004; dMissReq = 1'b1; left_d = 1;
    iMissAddr = 32'h0000_3001; iMissReq = 1'b1; left_i = 1;
    exp_q.push_back(mk(2'd2, 32'h0000_8000, {16{32'hC0FF_EE00}}));
    exp_q.push_back(mk(2'd1, 32'h0000_2000, '0));
    exp_q.push_back(mk(2'd0, 32'h0000_3000, '0));
    wait_idle(200);
    check("B_cnts", {cnt_e[7:0], cnt_d[7:0], cnt_i[7:0]}, 24'h010101);
    check("B_q_empty", exp_q.size(), 0);
    check("B_data_line", mcDataIn, {16{32'h5A5A_2000}});

    // Both fill requesters held for four fills: D, I, D, I.
    do_reset();
    noise = 1;
    dMissAddr = 32'h0000_4440; dMissReq = 1'b1; left_d = 2;
    iMissAddr = 32'h0000_5550; iMissReq = 1'b1; left_i = 2;
    exp_q.push_back(mk(2'd1, 32'h0000_4440, '0));
    exp_q.push_back(mk(2'd0, 32'h0000_5550, '0));
    exp_q.push_back(mk(2'd1, 32'h0000_4440, '0));
    exp_q.push_back(mk(2'd0, 32'h0000_5550, '0));
    wait_idle(300);
    check("C_cnts", {cnt_d[7:0], cnt_i[7:0]}, 16'h0202);
    check("C_q_empty", exp_q.size(), 0);
    check("C_instr_line", mcInstrIn, {16{32'h5A5A_5550}});

    // Reset while waiting for read data, then a late hostRdValid.
    do_reset();
    host_auto = 0;
    iMissAddr = 32'h0000_6660; iMissReq = 1'b1;
    exp_q.push_back(mk(2'd0, 32'h0000_6660, '0));
    wait_req(20);
    @(posedge clk); #1; hostReady = 1'b1;
    @(posedge clk); #1; hostReady = 1'b0;
    @(posedge clk); #1;
    check("D_busy_wait", busy, 1);
    rst = 1'b0;
    #1;
    check("D_async_busy", busy, 0);
    do_reset();
    hostRdValid = 1'b1; hostRdData = {16{32'h1234_5678}};
    @(posedge clk); #1; hostRdValid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("D_busy_after", busy, 0);
    check("D_line_after", mcInstrIn, 0);

    // Host never accepts.
    do_reset();
    iMissAddr = 32'h0000_7770; iMissReq = 1'b1;
    exp_q.push_back(mk(2'd0, 32'h0000_7770, '0));
    wait_req(20);
`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int k = 0;
      while (!timeoutErr && k < 1100) begin @(negedge clk); k++; end
      iMissReq = 1'b0;
      check("E_tmo_set", timeoutErr, 1);
      check("E_tmo_not_early", k >= 1000, 1);
      check("E_tmo_hostReq", hostReq, 0);
      check("E_tmo_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("E_tmo_sticky", timeoutErr, 1);
    end
`else
    repeat (1100) @(negedge clk);
    check("E_no_tmo", timeoutErr, 0);
    check("E_still_req", hostReq, 1);
`endif
    do_reset();
    host_auto = 1;
    repeat (3) @(negedge clk);
    check("E_tmo_cleared", timeoutErr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
